// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator APB scheduler.
// Register map, op encoding and FSM state type.
package calc_pkg;

  localparam logic [31:0] CALC_ADDR_A   = 32'h0000_0000;
  localparam logic [31:0] CALC_ADDR_B   = 32'h0000_0004;
  localparam logic [31:0] CALC_ADDR_OP  = 32'h0000_0008;
  localparam logic [31:0] CALC_ADDR_RES = 32'h0000_000C;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    SETUP,
    ACCESS,
    GAP,
    RESP
  } state_t;

  function automatic logic [31:0] step_addr(input logic [1:0] step);
    case (step)
      2'd0:    step_addr = CALC_ADDR_A;
      2'd1:    step_addr = CALC_ADDR_B;
      2'd2:    step_addr = CALC_ADDR_OP;
      default: step_addr = CALC_ADDR_RES;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid request after last_grant, with wrap.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] last_grant_i,
  input  logic                    en_i,
  output logic [NREQ-1:0]         grant_o,
  output logic [$clog2(NREQ)-1:0] grant_idx_o
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  logic                 found;
  int unsigned          cand;
  logic [IDX_W-1:0]     cidx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    cidx        = '0;
    if (en_i) begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        cand = (32'(last_grant_i) + k) % NREQ;
        cidx = IDX_W'(cand);
        if (!found && req_i[cidx]) begin
          found         = 1'b1;
          grant_o[cidx] = 1'b1;
          grant_idx_o   = cidx;
        end
      end
    end
  end

endmodule

// File: rtl/calc_apb_sched.sv
// APB master sharing the calculator slave between NREQ requesters:
// round-robin grant, then write A, write B, write op, gap, read result.
module calc_apb_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*DATA_W-1:0]    req_a,
  input  logic [NREQ*DATA_W-1:0]    req_b,
  input  logic [NREQ-1:0]           req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [31:0]               PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PREADY
);
  import calc_pkg::*;

  localparam int unsigned IDX_W  = $clog2(NREQ);
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  state_t              state_q, state_d;
  logic [1:0]          step_q, step_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic                op_q, op_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [IDX_W-1:0]    rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [31:0]         paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;

  logic [NREQ-1:0]     grant;
  logic [IDX_W-1:0]    grant_idx;
  logic [DATA_W-1:0]   a_sel, b_sel;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_q),
    .en_i         (state_q == ARB),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx)
  );

  assign req_ready = grant;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        a_sel = req_a[i*DATA_W +: DATA_W];
        b_sel = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    last_d     = last_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    wait_d     = wait_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      IDLE: if (|req_valid) state_d = ARB;
      ARB: begin
        // A requester may withdraw between IDLE and ARB; fall back to IDLE then.
        if (|grant) begin
          a_d      = a_sel;
          b_d      = b_sel;
          op_d     = req_op[grant_idx];
          last_d   = grant_idx;
          rsp_id_d = grant_idx;
          step_d   = 2'd0;
          state_d  = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        wait_d  = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          case (step_q)
            2'd0, 2'd1: begin
              step_d  = step_q + 2'd1;
              state_d = SETUP;
            end
            2'd2:    state_d = GAP;
            default: begin
              rsp_data_d = PRDATA;
              rsp_err_d  = 1'b0;
              state_d    = RESP;
            end
          endcase
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      GAP: begin
        step_d  = 2'd3;
        state_d = SETUP;
      end
      RESP: if (rsp_ready) state_d = (|req_valid) ? ARB : IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered from the next-state view so they align with the phase.
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    pwrite_d    = psel_d && (step_d != 2'd3);
    paddr_d     = psel_d ? step_addr(step_d) : '0;
    pwdata_d    = '0;
    if (pwrite_d) begin
      case (step_d)
        2'd0:    pwdata_d    = a_d;
        2'd1:    pwdata_d    = b_d;
        default: pwdata_d[0] = (op_d == OP_ADD);
      endcase
    end
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      step_q      <= '0;
      last_q      <= IDX_W'(NREQ - 1);
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_SUB;
      wait_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      last_q      <= last_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      wait_q      <= wait_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_calc_apb_sched.sv
// Bench for calc_apb_sched: behavioural calculator slave, transaction-level
// model of arbitration/latency/results, and directed plus random requests.
module tb_calc_apb_sched;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int TO   = 16;

  logic                 PCLK = 1'b0;
  logic                 PRESET;
  logic [NREQ-1:0]      req_valid, req_ready, req_op;
  logic [NREQ*DW-1:0]   req_a, req_b;
  logic                 rsp_valid, rsp_ready, rsp_err;
  logic [1:0]           rsp_id;
  logic [DW-1:0]        rsp_data, PWDATA, PRDATA;
  logic                 PSEL, PENABLE, PWRITE, PREADY;
  logic [31:0]          PADDR;

  calc_apb_sched #(.NREQ(NREQ), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] calc(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (op) return a + b;
    if (a >= b) return a - b;
    return (b - a) | 32'h8000_0000;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // slave_mode: 0 zero-wait, 1 two waits at address 0x4, 2 random 0..2 waits, 3 never ready
  int          slave_mode = 0;
  logic [31:0] sr_a, sr_b;
  logic        sr_op;
  int          s_need, s_wc;
  logic        s_done, s_wr;
  logic [31:0] s_addr, s_data;

  initial begin
    PREADY = 1'b0; PRDATA = '0; sr_a = '0; sr_b = '0; sr_op = 1'b0;
    s_need = 0; s_wc = 0; s_done = 1'b0; s_wr = 1'b0; s_addr = '0; s_data = '0;
    forever begin
      @(posedge PCLK); #2;
      if (s_done && s_wr && !PRESET) begin
        case (s_addr)
          32'h0:   sr_a  = s_data;
          32'h4:   sr_b  = s_data;
          32'h8:   sr_op = s_data[0];
          default: ;
        endcase
      end
      s_done = 1'b0;
      if (PSEL && !PENABLE) begin
        s_wc   = 0;
        s_need = (slave_mode == 1 && PADDR == 32'h4) ? 2 :
                 (slave_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        PREADY = 1'b0;
      end else if (PSEL && PENABLE) begin
        PREADY = (slave_mode != 3) && (s_wc >= s_need);
        s_wc++;
        s_done = PREADY; s_addr = PADDR; s_data = PWDATA; s_wr = PWRITE;
      end else begin
        PREADY = 1'b0;
      end
      PRDATA = calc(sr_a, sr_b, sr_op);
    end
  end

  // Transaction model and per-cycle compare
  int              mlast, e_id, t_grant, waits, nx, acc, c2, g;
  bit              active, in_resp, exp_err;
  logic [31:0]     e_a, e_b, snap_addr, snap_data, exp_d, rs_data;
  logic            e_op, snap_wr, rs_err;
  logic [1:0]      rs_id;
  int              rsp_cnt = 0;
  int              last_rsp_cyc = 0, last_grant_cyc = 0;
  int              grant_log[$];
  logic [NREQ-1:0] gmask = '0;

  always @(negedge PCLK) begin
    gmask = req_ready;
    if (PRESET) begin
      mlast = NREQ - 1; active = 0; in_resp = 0;
    end else begin
      if (req_ready != '0) begin
        g = rr_pick(req_valid, mlast);
        chk("grant_onehot", 64'($onehot(req_ready)), 1);
        chk("grant_idx", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        chk("grant_while_busy", 64'(active || in_resp), 0);
        if (g >= 0) begin
          active = 1; e_id = g; t_grant = cyc; waits = 0; nx = 0; acc = 0; c2 = 0;
          e_a = req_a[g*DW +: DW]; e_b = req_b[g*DW +: DW]; e_op = req_op[g];
          mlast = g; grant_log.push_back(g); last_grant_cyc = cyc;
        end
      end
      if (PSEL) begin
        chk("psel_without_txn", 64'(active), 1);
        if (!PENABLE) begin
          snap_addr = PADDR; snap_data = PWDATA; snap_wr = PWRITE; acc = 0;
          exp_d = (nx == 0) ? e_a : (nx == 1) ? e_b : (nx == 2) ? {31'b0, e_op} : 32'h0;
          chk("setup_addr", PADDR, 64'(nx * 4));
          chk("setup_pwrite", 64'(PWRITE), 64'(nx < 3));
          chk("setup_pwdata", PWDATA, exp_d);
          if (nx == 3) chk("gap_spacing", 64'(cyc - c2), 2);
        end else begin
          chk("access_hold", {PADDR, PWDATA}, {snap_addr, snap_data});
          chk("access_pwrite", 64'(PWRITE), 64'(snap_wr));
          acc++;
          if (PREADY) begin nx++; if (nx == 3) c2 = cyc; end
          else waits++;
        end
      end else begin
        chk("idle_ctrl", {PENABLE, PWRITE, PADDR}, 0);
        chk("idle_pwdata", PWDATA, 0);
      end
      if (rsp_valid) begin
        if (!in_resp) begin
          in_resp = 1; rsp_cnt++; last_rsp_cyc = cyc;
          exp_err = (slave_mode == 3);
          chk("rsp_unexpected", 64'(active), 1);
          chk("rsp_id", rsp_id, 64'(e_id));
          chk("rsp_err", 64'(rsp_err), 64'(exp_err));
          chk("rsp_data", rsp_data, exp_err ? 32'h0 : calc(e_a, e_b, e_op));
          chk("rsp_latency", 64'(cyc - t_grant), exp_err ? 64'(2 + TO) : 64'(10 + waits));
          if (exp_err) chk("timeout_access_cycles", 64'(acc), TO);
          else chk("xfer_count", 64'(nx), 4);
          rs_id = rsp_id; rs_data = rsp_data; rs_err = rsp_err; active = 0;
        end else begin
          chk("rsp_hold", {rsp_id, rsp_err, rsp_data}, {rs_id, rs_err, rs_data});
        end
        if (rsp_ready) in_resp = 0;
      end else begin
        chk("rsp_dropped", 64'(in_resp), 0);
      end
    end
  end

  // req_mode: 0 directed (drop on grant), 1 random, 2 hold valid after service
  int req_mode = 0;

  task automatic tick();
    @(posedge PCLK); #1;
    if (req_mode == 1) begin
      for (int i = 0; i < NREQ; i++) begin
        if (gmask[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b1;
          req_a[i*DW +: DW] = $urandom;
          req_b[i*DW +: DW] = $urandom;
          req_op[i] = 1'($urandom_range(0, 1));
        end else if (req_valid[i] && $urandom_range(0, 63) == 0) req_valid[i] = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end else if (req_mode == 0) begin
      req_valid = req_valid & ~gmask;
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
    req_a[i*DW +: DW] = a; req_b[i*DW +: DW] = b; req_op[i] = op; req_valid[i] = 1'b1;
  endtask

  task automatic wait_rsp();
    int n0, k;
    n0 = rsp_cnt; k = 0;
    while (rsp_cnt == n0 && k < 200) begin tick(); k++; end
    if (rsp_cnt == n0) chk("rsp_arrival", 0, 1);
  endtask

  int base, k;
  int exp_ord[5] = '{0, 1, 2, 3, 0};

  initial begin
    PRESET = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    chk("reset_ctrl", {req_ready, rsp_valid, rsp_id, rsp_err, PSEL, PENABLE, PWRITE}, 0);
    chk("reset_paddr", PADDR, 0);
    chk("reset_data", {rsp_data, PWDATA}, 0);
    PRESET = 1'b0;
    tick();

    // All requesters held valid: rotation starts at 0
    req_mode = 2; base = grant_log.size();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(10 * i + 5), 32'(i), 1'(i & 1));
    for (int n = 0; n < 5; n++) wait_rsp();
    req_valid = '0; req_mode = 0;
    tick();
    chk("rr_count", 64'(grant_log.size() - base), 5);
    if (grant_log.size() - base >= 5)
      for (int n = 0; n < 5; n++) chk("rr_order", 64'(grant_log[base + n]), 64'(exp_ord[n]));

    // Requester 0: 7 + 5
    set_req(0, 7, 5, 1'b1); wait_rsp();
    chk("t1_data", rs_data, 12);
    chk("t1_id", rs_id, 0);
    chk("t1_latency", 64'(last_rsp_cyc - last_grant_cyc), 10);

    // Requester 2: 3 - 10
    set_req(2, 3, 10, 1'b0); wait_rsp();
    chk("t2_data", rs_data, 32'h8000_0007);
    chk("t2_err", rs_err, 0);

    // Two wait states on the B write
    slave_mode = 1;
    set_req(1, 20, 22, 1'b0); wait_rsp();
    chk("t4_data", rs_data, 32'h8000_0002);
    chk("t4_latency", 64'(last_rsp_cyc - last_grant_cyc), 12);

    // Slave never ready, then normal service again
    slave_mode = 3;
    set_req(3, 1, 2, 1'b1); wait_rsp();
    chk("t5_err", rs_err, 1);
    chk("t5_data", rs_data, 0);
    chk("t5_latency", 64'(last_rsp_cyc - last_grant_cyc), 18);
    tick(); slave_mode = 0;
    set_req(0, 32'hFFFF_FFFF, 2, 1'b1); wait_rsp();
    chk("t5_next_data", rs_data, 1);
    chk("t5_next_err", rs_err, 0);

    // Stall response, then reset during step 1 of the next transaction
    rsp_ready = 1'b0;
    set_req(1, 100, 1, 1'b0); wait_rsp();
    repeat (5) tick();
    chk("stall_valid", 64'(rsp_valid), 1);
    chk("stall_data", rsp_data, 99);
    rsp_ready = 1'b1; tick(); tick();
    chk("stall_release", 64'(rsp_valid), 0);
    set_req(2, 8, 8, 1'b1);
    k = 0;
    while (!(PSEL && PADDR == 32'h4) && k < 50) begin tick(); k++; end
    chk("reach_step1", 64'(PSEL && PADDR == 32'h4), 1);
    PRESET = 1'b1; #1;
    chk("rst_bus", {PSEL, PENABLE, PWRITE, PADDR}, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_id, req_ready}, 0);
    chk("rst_data", {rsp_data, PWDATA}, 0);
    tick(); tick();
    set_req(0, 9, 4, 1'b1); set_req(2, 1, 1, 1'b1); set_req(3, 2, 1, 1'b0);
    PRESET = 1'b0;
    wait_rsp();
    chk("post_reset_id", rs_id, 0);
    chk("post_reset_data", rs_data, 13);

    // Random traffic, random waits and back-pressure
    slave_mode = 2; req_mode = 1;
    repeat (1500) tick();
    req_mode = 0; req_valid = '0; rsp_ready = 1'b1;
    k = 0;
    while ((active || in_resp || rsp_valid || PSEL) && k < 200) begin tick(); k++; end
    chk("drain", 64'(active || in_resp || rsp_valid || PSEL), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/calc_apb_sched.md
# calc_apb_sched

APB master that shares the calculator slave (a/b operand registers, add/sub flag, result) between `NREQ` requesters. A round-robin arbiter selects one requester. The block runs the fixed APB sequence write A, write B, write op, read result, then returns the result, tagged with the requester ID. It sits between the requester-side logic and the calculator's APB port, and is that slave's only master.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8
- `DATA_W`, 32: operand/result width
- `TIMEOUT`, 16: maximum ACCESS cycles to wait for `PREADY` before abort

Ports:
- `PCLK`  in  1  clock; all logic on rising edge
- `PRESET`  in  1  reset, asynchronous, active-high
- `req_valid`  in  NREQ  per-requester request
- `req_ready`  out  NREQ  one-hot one-cycle grant/capture pulse
- `req_a`  in  NREQ*DATA_W  operand A, requester i at bits [i*DATA_W +: DATA_W]
- `req_b`  in  NREQ*DATA_W  operand B, same packing
- `req_op`  in  NREQ  1 = add, 0 = subtract
- `rsp_valid`  out  1  result available; held until `rsp_ready`
- `rsp_ready`  in  1  consumer accepts result
- `rsp_id`  out  $clog2(NREQ)  index of served requester
- `rsp_data`  out  DATA_W  result as read from the slave
- `rsp_err`  out  1  1 = transaction aborted on timeout
- `PSEL`, `PENABLE`, `PWRITE`  out  1 each  APB control
- `PADDR`  out  32  APB address
- `PWDATA`  out  DATA_W  APB write data
- `PRDATA`  in  DATA_W  APB read data
- `PREADY`  in  1  slave ready

## Operation
- FSM states: IDLE, ARB, SETUP, ACCESS, GAP, RESP.
- **IDLE:** if any `req_valid` is high, go to ARB.
- **ARB:**
  - Grant the first valid index searching from (last_grant+1) mod NREQ upward with wrap.
  - Pulse `req_ready[g]`.
  - Capture a, b and op into local registers.
  - Update last_grant = g.
  - Set step = 0.
  - Go to SETUP.
  - Requester inputs are not sampled after the ARB cycle.
- Step table (`PADDR` / `PWRITE` / `PWDATA`):
  - 0: 0x0 / 1 / a
  - 1: 0x4 / 1 / b
  - 2: 0x8 / 1 / {31'b0, op}
  - 3: 0xC / 0 / don't care, drive 0
- **SETUP:** PSEL=1, PENABLE=0, address/data per step. Go to ACCESS.
- **ACCESS:** PSEL=1, PENABLE=1, address/data held stable.
  - On `PREADY`=1, transfer completes:
    - step 0 or 1: step++ and go to SETUP (PSEL stays high).
    - step 2: go to GAP.
    - step 3: latch `PRDATA` into `rsp_data`, set `rsp_err`=0, go to RESP.
- **GAP:** one cycle with PSEL=0. This lets the slave's registered result settle after the op write. Then step = 3 and go to SETUP.
- **Timeout:** a wait counter is cleared on SETUP entry and increments on each ACCESS cycle with `PREADY`=0.
  - When it reaches TIMEOUT: drop PSEL/PENABLE, set `rsp_err`=1 and `rsp_data`=0, go to RESP.
  - The remaining steps are skipped.
- **RESP:** `rsp_valid`=1, with `rsp_id`, `rsp_data`, `rsp_err` stable.
  - On `rsp_ready`, go to ARB if any `req_valid` is high, else IDLE.
- Result meaning (set by the slave): op=1 gives a+b mod 2^32. op=0 gives a−b when a≥b, otherwise (b−a) with bit 31 forced to 1.
- Outside SETUP/ACCESS, `PSEL`, `PENABLE` and `PWRITE` are 0 and `PADDR`/`PWDATA` are 0.

## Timing
- Reset, asynchronous: state IDLE, last_grant = NREQ−1 (requester 0 wins first). All outputs 0.
- Reset mid-transfer drops PSEL immediately. The in-flight request is lost; its requester must re-request.
- Zero-wait slave: `req_ready` pulse at cycle t, then:
  - SETUP/ACCESS pairs for steps 0–2 at t+1..t+6
  - GAP at t+7
  - step 3 SETUP at t+8 and ACCESS at t+9
  - `rsp_valid` from t+10
- Each `PREADY`=0 cycle adds one cycle of latency.
- A requester withdrawing `req_valid` before its grant is simply skipped.
- A requester that keeps `req_valid` high after service waits a full round-robin rotation if others are valid.
- Simultaneous `rsp_ready` and new requests cost one ARB cycle. There is no back-to-back grant bypass.

## Structure
- Package `calc_pkg` holds:
  - address constants CALC_ADDR_A=0x0, CALC_ADDR_B=0x4, CALC_ADDR_OP=0x8, CALC_ADDR_RES=0xC
  - op constants OP_SUB=0, OP_ADD=1
  - the FSM state enum
- Sub-module `rr_arbiter`, parameterized by NREQ:
  - inputs: request vector, last_grant, enable
  - outputs: one-hot grant and index; purely combinational
  - last_grant register lives in the top.

## Test plan
- Requester 0 only, a=7, b=5, op=1, zero-wait slave → APB writes 0x0=7, 0x4=5, 0x8=1. Then GAP, then read 0xC. `rsp_data`=12, `rsp_id`=0, `rsp_valid` at t+10.
- Requester 2, a=3, b=10, op=0 → `rsp_data`=0x80000007, `rsp_err`=0.
- All 4 requesters held valid continuously → grants in order 0,1,2,3,0. No requester is granted twice while another is waiting.
- Slave inserts 2 wait states on step 1 → PADDR/PWDATA stay stable through the waits. `rsp_valid` arrives 2 cycles later than zero-wait.
- Slave never asserts PREADY (TIMEOUT=16) → PSEL drops after 16 ACCESS cycles. `rsp_err`=1, `rsp_data`=0, and the next request is still served normally.
- Hold `rsp_ready`=0 for 5 cycles, then assert `PRESET` during step 1 → outputs hold stable while stalled. After reset, all outputs are 0 and the next grant goes to requester 0.
